// File: rtl/ann_layer_seq.sv
// ann_layer_seq: sequential multi-layer fully-connected inference engine.
// NODES physical MAC nodes are reused for every one of NUM_LAYERS layers.
// Coefficients stream in one input element per transfer (one word per node),
// each layer ends with a saturating activation step, and a final argmax scan
// selects the winning class.
// Optional feature macro: ANN_RELU_EN (ReLU on all layers except the last;
// when undefined the activation is identity everywhere).
// Handshake: a coefficient word transfers on a rising clk edge where
// coef_valid and coef_ready are both 1; coef_ready depends only on the FSM
// state (high in MAC), and coef_valid low simply stalls with no state change.
module ann_layer_seq #(
    parameter int DATA_W     = 16,
    parameter int FRAC       = 8,
    parameter int IN_SIZE    = 16,
    parameter int NODES      = 16,
    parameter int NUM_LAYERS = 3
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           start,
    input  logic [IN_SIZE-1:0][DATA_W-1:0] image,
    input  logic [NUM_LAYERS-1:0][7:0]     layer_nodes,
    input  logic                           coef_valid,
    input  logic [NODES-1:0][DATA_W-1:0]   coef_data,
    output logic                           coef_ready,
    output logic                           busy,
    output logic                           done,
    output logic [NODES-1:0][DATA_W-1:0]   result,
    output logic [$clog2(NODES)-1:0]       class_idx,
    output logic [$clog2(NUM_LAYERS):0]    layer_idx,
    output logic [2:0]                     o_dbg_state
);
    localparam int PIPE_N = (IN_SIZE > NODES) ? IN_SIZE : NODES;
    localparam int ACC_W  = 2 * DATA_W + $clog2(PIPE_N);
    localparam int CNT_W  = $clog2(PIPE_N + 1);
    localparam int NCNT_W = $clog2(NODES + 1);
    localparam int IDX_W  = $clog2(NODES);
    localparam int LAY_W  = $clog2(NUM_LAYERS) + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_MAC    = 3'd2,
        S_ACT    = 3'd3,
        S_ARGMAX = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                     r_state, w_next;
    logic signed [DATA_W-1:0]   r_pipe [PIPE_N];
    logic signed [ACC_W-1:0]    r_acc [NODES];
    logic signed [ACC_W-1:0]    w_prod [NODES];
    logic signed [DATA_W-1:0]   w_act [NODES];
    logic [CNT_W-1:0]           r_cnt, w_in_cnt;
    logic [LAY_W-1:0]           r_layer;
    logic [NCNT_W-1:0]          r_nodes [NUM_LAYERS];
    logic [NCNT_W-1:0]          w_cur_nodes, w_last_nodes;
    logic                       w_last_layer, w_hs, w_mac_end, w_arg_end, w_arg_take;
    logic signed [DATA_W-1:0]   w_pipe_sel, r_best_val;
    logic [IDX_W-1:0]           r_best_idx, w_arg_idx, r_class;
    logic [NODES-1:0][DATA_W-1:0] r_result;

    // Node counts outside 1..NODES are pulled back into range.
    function automatic logic [NCNT_W-1:0] clamp_nodes(input logic [7:0] n);
        if (n == 8'd0)
            return NCNT_W'(1);
        else if (int'(n) > NODES)
            return NCNT_W'(NODES);
        else
            return NCNT_W'(n);
    endfunction

    // Drop the fraction bits and saturate to the signed DATA_W range.
    function automatic logic signed [DATA_W-1:0] sat_q(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> FRAC;
        if (s > SAT_MAX)
            return SAT_MAX[DATA_W-1:0];
        else if (s < SAT_MIN)
            return SAT_MIN[DATA_W-1:0];
        else
            return s[DATA_W-1:0];
    endfunction

    // Datapath selects: per-layer counts, MAC products, activations, argmax step
    always_comb begin
        w_in_cnt     = (r_layer == '0) ? CNT_W'(IN_SIZE) : CNT_W'(r_nodes[r_layer - 1'b1]);
        w_cur_nodes  = r_nodes[r_layer];
        w_last_nodes = r_nodes[NUM_LAYERS-1];
        w_last_layer = (r_layer == LAY_W'(NUM_LAYERS - 1));
        w_hs         = coef_valid && coef_ready;
        w_mac_end    = w_hs && (r_cnt == w_in_cnt - 1'b1);
        w_pipe_sel   = r_pipe[r_cnt];
        w_arg_take   = (r_cnt == '0) || (w_pipe_sel > r_best_val);
        w_arg_idx    = w_arg_take ? IDX_W'(r_cnt) : r_best_idx;
        w_arg_end    = (r_cnt == CNT_W'(w_last_nodes) - 1'b1);
        for (int n = 0; n < NODES; n++) begin
            w_prod[n] = ACC_W'(w_pipe_sel) * ACC_W'($signed(coef_data[n]));
            w_act[n]  = sat_q(r_acc[n]);
`ifdef ANN_RELU_EN
            if (!w_last_layer && w_act[n][DATA_W-1])
                w_act[n] = '0;
`endif
        end
    end

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_LOAD;
            S_LOAD:   w_next = S_MAC;
            S_MAC:    if (w_mac_end) w_next = S_ACT;
            S_ACT:    w_next = w_last_layer ? S_ARGMAX : S_MAC;
            S_ARGMAX: if (w_arg_end) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Moore outputs and registered result ports
    always_comb begin
        coef_ready  = (r_state == S_MAC);
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DONE);
        result      = r_result;
        class_idx   = r_class;
        layer_idx   = r_layer;
        o_dbg_state = r_state;
    end

    // Datapath registers: image pipeline, accumulators, counters, argmax
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < PIPE_N; i++) r_pipe[i] <= '0;
            for (int n = 0; n < NODES; n++) r_acc[n] <= '0;
            for (int l = 0; l < NUM_LAYERS; l++) r_nodes[l] <= '0;
            r_cnt      <= '0;
            r_layer    <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
            r_class    <= '0;
            r_result   <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    for (int i = 0; i < PIPE_N; i++) r_pipe[i] <= '0;
                    for (int i = 0; i < IN_SIZE; i++) r_pipe[i] <= image[i];
                    for (int l = 0; l < NUM_LAYERS; l++) r_nodes[l] <= clamp_nodes(layer_nodes[l]);
                    for (int n = 0; n < NODES; n++) r_acc[n] <= '0;
                    r_cnt    <= '0;
                    r_layer  <= '0;
                    r_result <= '0;
                    r_class  <= '0;
                end
                S_MAC: begin
                    if (w_hs) begin
                        for (int n = 0; n < NODES; n++)
                            if (NCNT_W'(n) < w_cur_nodes) r_acc[n] <= r_acc[n] + w_prod[n];
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ACT: begin
                    // Inactive entries are zeroed so the next layer never sees stale data.
                    for (int i = 0; i < PIPE_N; i++) r_pipe[i] <= '0;
                    for (int n = 0; n < NODES; n++)
                        if (NCNT_W'(n) < w_cur_nodes) r_pipe[n] <= w_act[n];
                    for (int n = 0; n < NODES; n++) r_acc[n] <= '0;
                    r_cnt <= '0;
                    if (!w_last_layer) r_layer <= r_layer + 1'b1;
                end
                S_ARGMAX: begin
                    if (w_arg_take) r_best_val <= w_pipe_sel;
                    r_best_idx <= w_arg_idx;
                    r_cnt      <= r_cnt + 1'b1;
                    if (w_arg_end) begin
                        r_class <= w_arg_idx;
                        for (int n = 0; n < NODES; n++) r_result[n] <= r_pipe[n];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ann_layer_seq.sv
// Testbench for ann_layer_seq: randomized and directed inferences checked
// against a plain-arithmetic reference model of the layer computation.
`timescale 1ns/1ps
module tb_ann_layer_seq;
    localparam int DATA_W       = 16;
    localparam int FRAC         = 8;
    localparam int IN_SIZE      = 16;
    localparam int NODES        = 16;
    localparam int NUM_LAYERS   = 3;
    localparam int PIPE_N       = 16;
    localparam int IDX_W        = $clog2(NODES);
    localparam int LAY_W        = $clog2(NUM_LAYERS) + 1;
    localparam int CYCLE_BUDGET = 2000;
    localparam longint SAT_MAX  = 32767;
    localparam longint SAT_MIN  = -32768;

    // ---------------- clock / reset / DUT ----------------
    logic                           clk = 1'b0;
    logic                           n_rst = 1'b0;
    logic                           start = 1'b0;
    logic [IN_SIZE-1:0][DATA_W-1:0] image = '0;
    logic [NUM_LAYERS-1:0][7:0]     layer_nodes = '0;
    logic                           coef_valid = 1'b0;
    logic [NODES-1:0][DATA_W-1:0]   coef_data = '0;
    logic                           coef_ready;
    logic                           busy;
    logic                           done;
    logic [NODES-1:0][DATA_W-1:0]   result;
    logic [IDX_W-1:0]               class_idx;
    logic [LAY_W-1:0]               layer_idx;
    logic [2:0]                     o_dbg_state;

    always #5 clk = ~clk;

    ann_layer_seq #(
        .DATA_W(DATA_W), .FRAC(FRAC), .IN_SIZE(IN_SIZE), .NODES(NODES), .NUM_LAYERS(NUM_LAYERS)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .image(image), .layer_nodes(layer_nodes),
        .coef_valid(coef_valid), .coef_data(coef_data), .coef_ready(coef_ready),
        .busy(busy), .done(done), .result(result), .class_idx(class_idx),
        .layer_idx(layer_idx), .o_dbg_state(o_dbg_state)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus tables and scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int img [IN_SIZE];
    int ln_raw [NUM_LAYERS];
    int coef [NUM_LAYERS][PIPE_N][NODES];
    int g_nodes [NUM_LAYERS];
    int exp_class;
    int exp_lat;
    logic [DATA_W-1:0] exp_q [$];
    bit g_done_seen;
    int g_cycles;
    int g_cl;

    function automatic int clampn(input int n);
        if (n == 0) return 1;
        if (n > NODES) return NODES;
        return n;
    endfunction

    function automatic int m_in_cnt(input int l);
        return (l == 0) ? IN_SIZE : g_nodes[l-1];
    endfunction

    // Reference: each layer is a matrix-vector product, rescaled, saturated,
    // optionally rectified; then argmax with lowest index on ties.
    task automatic model_run();
        longint v [PIPE_N];
        longint nv [PIPE_N];
        longint acc, s;
        int best;
        for (int l = 0; l < NUM_LAYERS; l++) g_nodes[l] = clampn(ln_raw[l]);
        for (int i = 0; i < PIPE_N; i++) v[i] = (i < IN_SIZE) ? longint'(img[i]) : 0;
        exp_lat = 1;
        for (int l = 0; l < NUM_LAYERS; l++) begin
            exp_lat += m_in_cnt(l) + 1;
            for (int n = 0; n < PIPE_N; n++) nv[n] = 0;
            for (int n = 0; n < g_nodes[l]; n++) begin
                acc = 0;
                for (int k = 0; k < m_in_cnt(l); k++) acc += v[k] * longint'(coef[l][k][n]);
                s = acc >>> FRAC;
                if (s > SAT_MAX) s = SAT_MAX;
                if (s < SAT_MIN) s = SAT_MIN;
`ifdef ANN_RELU_EN
                if (l != NUM_LAYERS - 1 && s < 0) s = 0;
`endif
                nv[n] = s;
            end
            v = nv;
        end
        exp_lat += g_nodes[NUM_LAYERS-1] + 1;
        best = 0;
        for (int n = 1; n < g_nodes[NUM_LAYERS-1]; n++) if (v[n] > v[best]) best = n;
        exp_class = best;
        exp_q.delete();
        for (int n = 0; n < NODES; n++) exp_q.push_back(DATA_W'(v[n]));
    endtask

    task automatic fill_const(input int iv, input int c0, input int c1, input int c2);
        for (int i = 0; i < IN_SIZE; i++) img[i] = iv;
        for (int k = 0; k < PIPE_N; k++)
            for (int n = 0; n < NODES; n++) begin
                coef[0][k][n] = c0;
                coef[1][k][n] = c1;
                coef[2][k][n] = c2;
            end
    endtask

    task automatic fill_random();
        for (int i = 0; i < IN_SIZE; i++) img[i] = int'($urandom_range(0, 2047)) - 1024;
        for (int l = 0; l < NUM_LAYERS; l++)
            for (int k = 0; k < PIPE_N; k++)
                for (int n = 0; n < NODES; n++) coef[l][k][n] = int'($urandom_range(0, 600)) - 300;
    endtask

    // ---------------- driver ----------------
    // Pulses start, then streams coefficients in order; returns at the
    // negedge where done is seen, at abort_cyc, or when the budget expires.
    task automatic run_inference(input int stall_l, input int stall_k, input int stall_len,
                                 input int restart_cyc, input int abort_cyc);
        int ck, cyc, stall_left;
        bit hs;
        g_done_seen = 1'b0;
        g_cycles = 0;
        g_cl = 0;
        ck = 0;
        stall_left = stall_len;
        for (int i = 0; i < IN_SIZE; i++) image[i] = DATA_W'(img[i]);
        for (int l = 0; l < NUM_LAYERS; l++) layer_nodes[l] = 8'(ln_raw[l]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < CYCLE_BUDGET) begin
            if (cyc == abort_cyc) break;
            if (done === 1'b1) begin
                g_done_seen = 1'b1;
                g_cycles = cyc;
                break;
            end
            start = (cyc == restart_cyc);
            coef_valid = 1'b1;
            if (stall_left > 0 && coef_ready === 1'b1 && g_cl == stall_l && ck == stall_k) begin
                coef_valid = 1'b0;
                stall_left--;
            end
            if (g_cl < NUM_LAYERS)
                for (int n = 0; n < NODES; n++) coef_data[n] = DATA_W'(coef[g_cl][ck][n]);
            hs = coef_valid && (coef_ready === 1'b1);
            @(negedge clk);
            cyc++;
            if (hs) begin
                ck++;
                if (ck == m_in_cnt(g_cl)) begin
                    ck = 0;
                    g_cl++;
                end
            end
        end
        start = 1'b0;
        coef_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (coef_ready !== 1'b0) begin n_errors++; $display("FAIL reset_coef_ready: got %b want 0", coef_ready); end
        n_checks++; if (result !== '0) begin n_errors++; $display("FAIL reset_result: got %h want 0", result); end
        n_checks++; if (class_idx !== '0) begin n_errors++; $display("FAIL reset_class_idx: got %0d want 0", class_idx); end
        n_checks++; if (layer_idx !== '0) begin n_errors++; $display("FAIL reset_layer_idx: got %0d want 0", layer_idx); end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_all_ones();
        int stall;
        for (int s = 0; s < 2; s++) begin
            stall = (s == 0) ? 0 : 3;
            ln_raw = '{16, 4, 10};
            fill_const(256, 256, 256, 256);
            model_run();
            run_inference(0, 6, stall, 0, 0);
            n_checks++; if (!g_done_seen) begin n_errors++; $display("FAIL ones%0d_done: no done within %0d cycles", s, CYCLE_BUDGET); end
            n_checks++; if (g_cycles !== 51 + stall) begin n_errors++; $display("FAIL ones%0d_latency: got %0d want %0d", s, g_cycles, 51 + stall); end
            for (int n = 0; n < NODES; n++) begin
                n_checks++;
                if (result[n] !== exp_q[n]) begin n_errors++; $display("FAIL ones%0d_result[%0d]: got %0d want %0d", s, n, $signed(result[n]), $signed(exp_q[n])); end
            end
            n_checks++; if (class_idx !== IDX_W'(exp_class)) begin n_errors++; $display("FAIL ones%0d_class: got %0d want %0d", s, class_idx, exp_class); end
            n_checks++; if (layer_idx !== LAY_W'(NUM_LAYERS - 1)) begin n_errors++; $display("FAIL ones%0d_layer_idx: got %0d want %0d", s, layer_idx, NUM_LAYERS - 1); end
            n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL ones%0d_busy_done: got %b want 1", s, busy); end
            @(negedge clk);
            n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL ones%0d_after_done: done=%b busy=%b want 0 0", s, done, busy); end
            repeat (3) @(negedge clk);
            n_checks++; if (result[0] !== exp_q[0] || class_idx !== IDX_W'(exp_class)) begin n_errors++; $display("FAIL ones%0d_hold: result0=%0d class=%0d want %0d %0d", s, $signed(result[0]), class_idx, $signed(exp_q[0]), exp_class); end
        end
    endtask

    task automatic test_argmax();
        for (int c = 0; c < 2; c++) begin
            ln_raw = '{16, 4, 10};
            fill_const(256, 16, 16, 256);
            for (int k = 0; k < PIPE_N; k++) begin
                coef[2][k][7] = 512;
                if (c == 1) coef[2][k][3] = 512;
            end
            model_run();
            run_inference(0, 0, 0, 0, 0);
            n_checks++; if (!g_done_seen) begin n_errors++; $display("FAIL argmax%0d_done: no done within %0d cycles", c, CYCLE_BUDGET); end
            for (int n = 0; n < NODES; n++) begin
                n_checks++;
                if (result[n] !== exp_q[n]) begin n_errors++; $display("FAIL argmax%0d_result[%0d]: got %0d want %0d", c, n, $signed(result[n]), $signed(exp_q[n])); end
            end
            n_checks++; if (class_idx !== IDX_W'(exp_class)) begin n_errors++; $display("FAIL argmax%0d_class: got %0d want %0d", c, class_idx, exp_class); end
            n_checks++; if (class_idx !== IDX_W'((c == 0) ? 7 : 3)) begin n_errors++; $display("FAIL argmax%0d_class_fixed: got %0d want %0d", c, class_idx, (c == 0) ? 7 : 3); end
        end
    endtask

    task automatic test_negative();
        ln_raw = '{16, 4, 10};
        fill_const(256, -256, 256, 256);
        model_run();
        run_inference(0, 0, 0, 0, 0);
        n_checks++; if (!g_done_seen) begin n_errors++; $display("FAIL neg_done: no done within %0d cycles", CYCLE_BUDGET); end
        n_checks++; if (g_cycles !== exp_lat) begin n_errors++; $display("FAIL neg_latency: got %0d want %0d", g_cycles, exp_lat); end
        for (int n = 0; n < NODES; n++) begin
            n_checks++;
            if (result[n] !== exp_q[n]) begin n_errors++; $display("FAIL neg_result[%0d]: got %0d want %0d", n, $signed(result[n]), $signed(exp_q[n])); end
        end
        n_checks++; if (class_idx !== IDX_W'(exp_class)) begin n_errors++; $display("FAIL neg_class: got %0d want %0d", class_idx, exp_class); end
    endtask

    task automatic test_clamp_and_busy_start();
        bit stray;
        ln_raw = '{0, 20, 4};
        fill_random();
        model_run();
        run_inference(0, 0, 0, 10, 0);
        n_checks++; if (!g_done_seen) begin n_errors++; $display("FAIL clamp_done: no done within %0d cycles", CYCLE_BUDGET); end
        n_checks++; if (g_cycles !== 42) begin n_errors++; $display("FAIL clamp_latency: got %0d want 42", g_cycles); end
        for (int n = 0; n < NODES; n++) begin
            n_checks++;
            if (result[n] !== exp_q[n]) begin n_errors++; $display("FAIL clamp_result[%0d]: got %0d want %0d", n, $signed(result[n]), $signed(exp_q[n])); end
        end
        n_checks++; if (class_idx !== IDX_W'(exp_class)) begin n_errors++; $display("FAIL clamp_class: got %0d want %0d", class_idx, exp_class); end
        stray = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i > 0 && (busy !== 1'b0 || done !== 1'b0)) stray = 1'b1;
        end
        n_checks++; if (stray) begin n_errors++; $display("FAIL busy_start_ignored: got activity after done want idle"); end
    endtask

    task automatic test_reset_abort();
        bit stray;
        ln_raw = '{16, 4, 10};
        fill_const(256, 256, 256, 256);
        model_run();
        run_inference(0, 0, 0, 0, 25);
        n_checks++; if (layer_idx !== LAY_W'(g_cl) || g_cl != 1) begin n_errors++; $display("FAIL abort_layer_idx: got %0d want 1 (bench layer %0d)", layer_idx, g_cl); end
        n_rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || coef_ready !== 1'b0) begin n_errors++; $display("FAIL abort_ctrl: busy=%b done=%b ready=%b want 0 0 0", busy, done, coef_ready); end
        n_checks++; if (result !== '0 || class_idx !== '0 || layer_idx !== '0) begin n_errors++; $display("FAIL abort_outputs: class=%0d layer=%0d result nonzero=%b want 0", class_idx, layer_idx, result != '0); end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        n_checks++; if (stray) begin n_errors++; $display("FAIL abort_no_done: got activity after reset want idle"); end
        fill_random();
        model_run();
        run_inference(0, 0, 0, 0, 0);
        n_checks++; if (!g_done_seen) begin n_errors++; $display("FAIL abort_rerun_done: no done within %0d cycles", CYCLE_BUDGET); end
        for (int n = 0; n < NODES; n++) begin
            n_checks++;
            if (result[n] !== exp_q[n]) begin n_errors++; $display("FAIL abort_rerun_result[%0d]: got %0d want %0d", n, $signed(result[n]), $signed(exp_q[n])); end
        end
        n_checks++; if (class_idx !== IDX_W'(exp_class)) begin n_errors++; $display("FAIL abort_rerun_class: got %0d want %0d", class_idx, exp_class); end
    endtask

    task automatic test_random();
        int sl, sk, slen;
        for (int r = 0; r < 6; r++) begin
            for (int l = 0; l < NUM_LAYERS; l++) ln_raw[l] = int'($urandom_range(0, 20));
            fill_random();
            model_run();
            sl = int'($urandom_range(0, NUM_LAYERS - 1));
            sk = int'($urandom_range(0, m_in_cnt(sl) - 1));
            slen = int'($urandom_range(0, 4));
            run_inference(sl, sk, slen, 0, 0);
            n_checks++; if (!g_done_seen) begin n_errors++; $display("FAIL rand%0d_done: no done within %0d cycles", r, CYCLE_BUDGET); end
            n_checks++; if (g_cycles !== exp_lat + slen) begin n_errors++; $display("FAIL rand%0d_latency: got %0d want %0d", r, g_cycles, exp_lat + slen); end
            for (int n = 0; n < NODES; n++) begin
                n_checks++;
                if (result[n] !== exp_q[n]) begin n_errors++; $display("FAIL rand%0d_result[%0d]: got %0d want %0d", r, n, $signed(result[n]), $signed(exp_q[n])); end
            end
            n_checks++; if (class_idx !== IDX_W'(exp_class)) begin n_errors++; $display("FAIL rand%0d_class: got %0d want %0d", r, class_idx, exp_class); end
            repeat (2) @(negedge clk);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_all_ones();
        test_argmax();
        test_negative();
        test_clamp_and_busy_start();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end
endmodule
